// File: rtl/cia_sp_peer.sv
// Serial-port peer for a CIA SP/CNT link: drives CNT/SP to send a byte MSB first,
// or samples SP on CNT rising edges to receive one, with overrun and partial-byte timeout.
module cia_sp_peer #(
    parameter int TIMEOUT     = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       mode_tx,
    input  logic [7:0] half_period,
    input  logic       cnt_in,
    input  logic       sp_in,
    output logic       cnt_out,
    output logic       cnt_oe,
    output logic       sp_out,
    output logic       sp_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       busy
);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} tx_state_t;

    // Input synchronisers
    logic [SYNC_STAGES-1:0] cnt_sync_q, cnt_sync_d;
    logic [SYNC_STAGES-1:0] sp_sync_q, sp_sync_d;
    logic                   cnt_prev_q;
    logic                   cnt_s, sp_s, cnt_rise;

    generate
        if (SYNC_STAGES == 1) begin : g_sync1
            assign cnt_sync_d = cnt_in;
            assign sp_sync_d  = sp_in;
        end else begin : g_syncn
            assign cnt_sync_d = {cnt_sync_q[SYNC_STAGES-2:0], cnt_in};
            assign sp_sync_d  = {sp_sync_q[SYNC_STAGES-2:0], sp_in};
        end
    endgenerate

    assign cnt_s    = cnt_sync_q[SYNC_STAGES-1];
    assign sp_s     = sp_sync_q[SYNC_STAGES-1];
    assign cnt_rise = cnt_s & ~cnt_prev_q & ~mode_tx;

    // Receive state
    logic [6:0]    rx_shift_q;
    logic [2:0]    rx_cnt_q;
    logic [TW-1:0] idle_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q, rx_overrun_q;
    logic          rx_accept, byte_done, byte_drop;

    assign rx_accept = rx_valid_q & rx_ready;
    assign byte_done = cnt_rise & (rx_cnt_q == 3'd7);
    assign byte_drop = byte_done & rx_valid_q & ~rx_ready;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_sync_q   <= '1;
            sp_sync_q    <= '1;
            cnt_prev_q   <= 1'b1;
            rx_shift_q   <= '0;
            rx_cnt_q     <= '0;
            idle_q       <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            cnt_sync_q <= cnt_sync_d;
            sp_sync_q  <= sp_sync_d;
            cnt_prev_q <= cnt_s;

            if (mode_tx) begin
                rx_cnt_q   <= '0;
                rx_shift_q <= '0;
                idle_q     <= '0;
            end else if (cnt_rise) begin
                rx_shift_q <= {rx_shift_q[5:0], sp_s};
                rx_cnt_q   <= rx_cnt_q + 3'd1;
                idle_q     <= '0;
            end else if (rx_cnt_q != 3'd0) begin
                // Stalled partial byte: drop it so the next byte starts aligned
                if (idle_q == IDLE_LAST) begin
                    rx_cnt_q   <= '0;
                    rx_shift_q <= '0;
                    idle_q     <= '0;
                end else begin
                    idle_q <= idle_q + 1'b1;
                end
            end else begin
                idle_q <= '0;
            end

            if (byte_done && !byte_drop) begin
                rx_data_q  <= {rx_shift_q, sp_s};
                rx_valid_q <= 1'b1;
            end else if (rx_accept) begin
                rx_valid_q <= 1'b0;
            end

            if (rx_accept) begin
                rx_overrun_q <= 1'b0;
            end else if (byte_drop) begin
                rx_overrun_q <= 1'b1;
            end
        end
    end

    // Transmit FSM
    tx_state_t  state_q;
    logic [7:0] h_q, phase_q, tx_byte_q;
    logic [2:0] bit_idx_q;
    logic       cnt_out_q, sp_out_q, tx_done_q, run_q;
    logic [7:0] h_d;
    logic       phase_last, tx_ready_w;

    assign h_d        = (half_period == 8'd0) ? 8'd1 : half_period;
    assign phase_last = (phase_q == h_q - 8'd1);
    assign tx_ready_w = mode_tx & run_q & (state_q == S_IDLE);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= S_IDLE;
            h_q       <= 8'd1;
            phase_q   <= '0;
            tx_byte_q <= '0;
            bit_idx_q <= '0;
            cnt_out_q <= 1'b1;
            sp_out_q  <= 1'b1;
            tx_done_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            tx_done_q <= 1'b0;
            if (!mode_tx) begin
                state_q   <= S_IDLE;
                cnt_out_q <= 1'b1;
                sp_out_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (tx_valid && tx_ready_w) begin
                            tx_byte_q <= tx_data;
                            sp_out_q  <= tx_data[7];
                            bit_idx_q <= '0;
                            phase_q   <= '0;
                            h_q       <= h_d;
                            state_q   <= S_HI;
                        end
                    end
                    S_HI: begin
                        if (phase_last) begin
                            cnt_out_q <= 1'b0;
                            phase_q   <= '0;
                            state_q   <= S_LO;
                        end else begin
                            phase_q <= phase_q + 8'd1;
                        end
                    end
                    S_LO: begin
                        if (phase_last) begin
                            cnt_out_q <= 1'b1;
                            phase_q   <= '0;
                            if (bit_idx_q == 3'd7) begin
                                sp_out_q  <= 1'b1;
                                tx_done_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end else begin
                                // SP moves only together with the CNT rising edge
                                sp_out_q  <= tx_byte_q[6];
                                tx_byte_q <= {tx_byte_q[6:0], 1'b0};
                                bit_idx_q <= bit_idx_q + 3'd1;
                                state_q   <= S_HI;
                            end
                        end else begin
                            phase_q <= phase_q + 8'd1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign cnt_oe     = mode_tx;
    assign sp_oe      = mode_tx;
    assign cnt_out    = cnt_out_q;
    assign sp_out     = sp_out_q;
    assign tx_ready   = tx_ready_w;
    assign tx_done    = tx_done_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_overrun_q;
    assign busy       = (state_q != S_IDLE) | (rx_cnt_q != 3'd0);

endmodule

// File: tb/tb_cia_sp_peer.sv
// Bench for cia_sp_peer: a table of rx/tx byte transactions checked through
// scoreboard queues, plus hand-written overrun, timeout, abort and reset sequences.
module tb_cia_sp_peer;
    localparam int TO = 100;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       mode_tx = 1'b1;
    logic [7:0] half_period = 8'd4;
    logic       cnt_in = 1'b1;
    logic       sp_in = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_ready = 1'b1;
    logic       cnt_out, cnt_oe, sp_out, sp_oe, tx_ready, tx_done;
    logic [7:0] rx_data;
    logic       rx_valid, rx_overrun, busy;

    cia_sp_peer #(.TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
        .clk(clk), .res_n(res_n), .mode_tx(mode_tx), .half_period(half_period),
        .cnt_in(cnt_in), .sp_in(sp_in), .cnt_out(cnt_out), .cnt_oe(cnt_oe),
        .sp_out(sp_out), .sp_oe(sp_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_done(tx_done), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_overrun(rx_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_tx;
        logic [7:0] data;
        logic [7:0] hp;
        int         exp_cycles;
        logic [7:0] exp_byte;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        int         cycles;
    } txexp_t;

    logic [7:0] rxq[$];
    txexp_t     txq[$];
    int         checks = 0;
    int         failures = 0;
    int         hs_count = 0;
    int         falls = 0;
    int         acc_cyc = 0;
    logic [7:0] asm_b = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receive side scoreboard: one pop per accepted handshake
    task automatic rx_mon();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (res_n && rx_valid && rx_ready) begin
                hs_count++;
                if (rxq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected actual=0x%0h required=none", rx_data);
                end else begin
                    e = rxq.pop_front();
                    chk("rx_data", {24'd0, rx_data}, {24'd0, e});
                    $display("rx byte 0x%02h expected 0x%02h", rx_data, e);
                end
            end
        end
    endtask

    // Transmit side: rebuild the byte from SP at each CNT falling edge
    task automatic tx_mon();
        logic   prev_cnt = 1'b1;
        logic   prev_sp = 1'b1;
        txexp_t e;
        forever begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                falls   = 0;
                acc_cyc = cyc + 1;  // acceptance edge is the coming posedge
            end
            if (prev_cnt && !cnt_out) begin
                chk("sp_stable_at_fall", {31'd0, sp_out}, {31'd0, prev_sp});
                asm_b = {asm_b[6:0], sp_out};
                falls++;
            end
            if (!prev_cnt && !cnt_out && sp_out !== prev_sp) begin
                checks++;
                failures++;
                $display("FAIL sp_change_while_cnt_low actual=%b required=%b", sp_out, prev_sp);
            end
            if (tx_done) begin
                if (txq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_done_unexpected actual=1 required=0");
                end else begin
                    e = txq.pop_front();
                    chk("tx_byte", {24'd0, asm_b}, {24'd0, e.b});
                    chk("tx_cycles", cyc - acc_cyc, e.cycles);
                    chk("tx_falls", falls, 8);
                    $display("tx byte 0x%02h in %0d cycles, expected 0x%02h in %0d",
                             asm_b, cyc - acc_cyc, e.b, e.cycles);
                end
            end
            prev_cnt = cnt_out;
            prev_sp  = sp_out;
        end
    endtask

    task automatic send_rx_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            sp_in  = b[i];
            cnt_in = 1'b0;
            repeat (10) tick();
            cnt_in = 1'b1;
            repeat (10) tick();
        end
    endtask

    task automatic wait_rxq_empty(input string name);
        int n = 0;
        while (rxq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(name, rxq.size(), 0);
    endtask

    task automatic wait_txq_empty(input string name);
        int n = 0;
        while (txq.size() != 0 && n < 5000) begin
            tick();
            n++;
        end
        chk(name, txq.size(), 0);
    endtask

    task automatic do_tx(input logic [7:0] d, input logic [7:0] hp);
        int n = 0;
        tick();
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        half_period = hp;
        tx_data     = d;
        tx_valid    = 1'b1;
        tick();
        tx_valid    = 1'b0;
        half_period = 8'd9;  // must not disturb the byte in flight
        tx_data     = ~d;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 8'd0, 0,  8'hA5};
        vecs[1] = '{1'b1, 8'h81, 8'd4, 64, 8'h81};
        vecs[2] = '{1'b1, 8'h5A, 8'd0, 16, 8'h5A};
        vecs[3] = '{1'b0, 8'h00, 8'd0, 0,  8'h00};
        vecs[4] = '{1'b1, 8'hC3, 8'd1, 16, 8'hC3};
        vecs[5] = '{1'b0, 8'hFF, 8'd0, 0,  8'hFF};
        vecs[6] = '{1'b1, 8'h3C, 8'd3, 48, 8'h3C};
        vecs[7] = '{1'b0, 8'h69, 8'd0, 0,  8'h69};

        fork
            rx_mon();
            tx_mon();
        join_none

        // Reset values, held with mode_tx=1 so tx_ready must still be low
        repeat (3) @(negedge clk);
        chk("rst_cnt_out", {31'd0, cnt_out}, 32'd1);
        chk("rst_sp_out", {31'd0, sp_out}, 32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        chk("rst_tx_done", {31'd0, tx_done}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_overrun", {31'd0, rx_overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt_oe", {31'd0, cnt_oe}, 32'd1);
        $display("reset values checked");
        tick();
        res_n = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_tx) begin
                mode_tx = 1'b1;
                tick();
                chk("oe_tx", {30'd0, cnt_oe, sp_oe}, 32'd3);
                txq.push_back('{vecs[i].exp_byte, vecs[i].exp_cycles});
                do_tx(vecs[i].data, vecs[i].hp);
                wait_txq_empty("tx_complete");
                @(negedge clk);
                chk("tx_idle_lines", {30'd0, cnt_out, sp_out}, 32'd3);
            end else begin
                mode_tx  = 1'b0;
                rx_ready = 1'b1;
                tick();
                chk("oe_rx", {30'd0, cnt_oe, sp_oe}, 32'd0);
                rxq.push_back(vecs[i].exp_byte);
                send_rx_bits(vecs[i].data, 8);
                wait_rxq_empty("rx_complete");
                chk("rx_no_overrun", {31'd0, rx_overrun}, 32'd0);
            end
        end

        // Overrun: second byte lost while first is unread
        mode_tx  = 1'b0;
        rx_ready = 1'b0;
        send_rx_bits(8'h3C, 8);
        repeat (5) tick();
        chk("ovr_first_valid", {31'd0, rx_valid}, 32'd1);
        send_rx_bits(8'hC3, 8);
        repeat (5) tick();
        chk("ovr_data_kept", {24'd0, rx_data}, 32'h3C);
        chk("ovr_flag", {31'd0, rx_overrun}, 32'd1);
        $display("overrun: rx_data=0x%02h rx_overrun=%b", rx_data, rx_overrun);
        rxq.push_back(8'h3C);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        @(negedge clk);
        chk("ovr_valid_clear", {31'd0, rx_valid}, 32'd0);
        chk("ovr_flag_clear", {31'd0, rx_overrun}, 32'd0);
        chk("ovr_popped", rxq.size(), 0);
        rx_ready = 1'b1;

        // Timeout discards a 3-bit fragment
        begin
            int hs0;
            hs0 = hs_count;
            send_rx_bits(8'hE0, 3);
            chk("to_busy_partial", {31'd0, busy}, 32'd1);
            repeat (TO + 20) tick();
            chk("to_busy_cleared", {31'd0, busy}, 32'd0);
            rxq.push_back(8'h55);
            send_rx_bits(8'h55, 8);
            wait_rxq_empty("to_rx_complete");
            repeat (20) tick();
            chk("to_one_valid", hs_count - hs0, 1);
            $display("timeout: handshakes after fragment = %0d", hs_count - hs0);
        end

        // Transmit abort after the third falling edge
        mode_tx = 1'b1;
        do_tx(8'h00, 8'd4);
        begin
            int n = 0;
            while (falls < 3 && n < 200) begin
                tick();
                n++;
            end
        end
        chk("abort_falls", falls, 3);
        chk("abort_sp_low", {31'd0, sp_out}, 32'd0);
        mode_tx = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_lines", {30'd0, cnt_out, sp_out}, 32'd3);
        chk("abort_oe", {31'd0, cnt_oe}, 32'd0);
        repeat (150) tick();
        chk("abort_idle", {31'd0, busy}, 32'd0);
        $display("abort: cnt_out=%b sp_out=%b", cnt_out, sp_out);

        // Asynchronous reset in the middle of a receive
        send_rx_bits(8'hA5, 4);
        chk("mid_rx_busy", {31'd0, busy}, 32'd1);
        res_n = 1'b0;
        #1;
        chk("arst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_lines", {30'd0, cnt_out, sp_out}, 32'd3);
        chk("arst_flags", {28'd0, tx_ready, tx_done, rx_valid, rx_overrun}, 32'd0);
        repeat (3) tick();
        res_n = 1'b1;
        send_rx_bits(8'h50, 4);
        repeat (20) tick();
        chk("post_rst_no_valid", {31'd0, rx_valid}, 32'd0);
        chk("post_rst_partial", {31'd0, busy}, 32'd1);
        repeat (TO + 20) tick();
        chk("post_rst_to", {31'd0, busy}, 32'd0);
        $display("reset mid-rx: rx_valid=%b busy=%b", rx_valid, busy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
